// File: rtl/heap_ctrl.sv
// heap_ctrl: a binary min-heap priority queue built on a register array.
// Keys are compared as unsigned values. A push writes the new key at the
// tail and sifts it up. A pop returns the root, moves the tail key to the
// root and sifts it down. Each sift cycle does at most one swap.
//
// Ports
//   clk, rst     : clock and asynchronous active-high reset
//   push_valid   : push request (held by the requester until acknowledged)
//   pop_valid    : pop request; takes priority over a simultaneous push
//   push_data    : key to insert
//   ready        : controller is idle and accepts a request this cycle
//   push_ack     : one-cycle pulse for an accepted push
//   pop_ack      : one-cycle pulse for an accepted pop
//   resp_data    : minimum key removed by the last accepted pop
//   count        : number of stored entries
//   full, empty  : count==DEPTH / count==0
//   err          : one-cycle pulse for a push while full or a pop while empty
module heap_ctrl #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic                     pop_valid,
  input  logic [DATA_W-1:0]        push_data,
  output logic                     ready,
  output logic                     push_ack,
  output logic                     pop_ack,
  output logic [DATA_W-1:0]        resp_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  typedef logic [IW-1:0] idx_t;

  logic [DATA_W-1:0] heap_q [DEPTH];

  logic [1:0]        state_q, state_d;
  idx_t              idx_q, idx_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic              push_ack_q, push_ack_d;
  logic              pop_ack_q, pop_ack_d;
  logic              err_q, err_d;

  // Up to two heap writes per cycle: one for push/pop, two for a swap.
  logic              we_a, we_b;
  idx_t              wa_idx, wb_idx;
  logic [DATA_W-1:0] wa_data, wb_data;

  // Helper indices. Child indices are one bit wider than count so that
  // out-of-range children compare correctly against count.
  idx_t          last_i, par_i, lc_i, rc_i, sel_i;
  logic [CW:0]   lc_w, rc_w, sel_lc_w, count_ext;
  logic          lc_ok, rc_ok;

  assign ready     = (state_q == S_IDLE);
  assign push_ack  = push_ack_q;
  assign pop_ack   = pop_ack_q;
  assign err       = err_q;
  assign resp_data = resp_q;
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);

  // When count==DEPTH the low bits wrap to 0, so subtracting one still
  // yields DEPTH-1.
  assign last_i    = count_q[IW-1:0] - idx_t'(1);
  assign par_i     = (idx_q - idx_t'(1)) >> 1;
  assign count_ext = {1'b0, count_q};
  assign lc_w      = {1'b0, idx_q, 1'b1};
  assign rc_w      = lc_w + (CW+1)'(1);
  assign lc_i      = lc_w[IW-1:0];
  assign rc_i      = rc_w[IW-1:0];
  assign lc_ok     = (lc_w < count_ext);
  assign rc_ok     = (rc_w < count_ext);
  // Left child wins ties.
  assign sel_i     = (rc_ok && (heap_q[rc_i] < heap_q[lc_i])) ? rc_i : lc_i;
  assign sel_lc_w  = {1'b0, sel_i, 1'b1};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    resp_d     = resp_q;
    push_ack_d = 1'b0;
    pop_ack_d  = 1'b0;
    err_d      = 1'b0;
    we_a       = 1'b0;
    wa_idx     = '0;
    wa_data    = '0;
    we_b       = 1'b0;
    wb_idx     = '0;
    wb_data    = '0;
    case (state_q)
      S_IDLE: begin
        if (pop_valid) begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            resp_d    = heap_q[0];
            we_a      = 1'b1;
            wa_idx    = '0;
            wa_data   = heap_q[last_i];
            count_d   = count_q - CW'(1);
            pop_ack_d = 1'b1;
            idx_d     = '0;
            // Only sift when at least two entries remain.
            if (count_q >= CW'(3)) state_d = S_DOWN;
          end
        end else if (push_valid) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            we_a       = 1'b1;
            wa_idx     = count_q[IW-1:0];
            wa_data    = push_data;
            count_d    = count_q + CW'(1);
            push_ack_d = 1'b1;
            idx_d      = count_q[IW-1:0];
            if (count_q != '0) state_d = S_UP;
          end
        end
      end
      S_UP: begin
        state_d = S_IDLE;
        if ((idx_q != '0) && (heap_q[idx_q] < heap_q[par_i])) begin
          we_a    = 1'b1;
          wa_idx  = par_i;
          wa_data = heap_q[idx_q];
          we_b    = 1'b1;
          wb_idx  = idx_q;
          wb_data = heap_q[par_i];
          idx_d   = par_i;
          // Reaching the root ends the sift on the swap cycle itself.
          if (par_i != '0) state_d = S_UP;
        end
      end
      S_DOWN: begin
        state_d = S_IDLE;
        if (lc_ok && (heap_q[sel_i] < heap_q[idx_q])) begin
          we_a    = 1'b1;
          wa_idx  = idx_q;
          wa_data = heap_q[sel_i];
          we_b    = 1'b1;
          wb_idx  = sel_i;
          wb_data = heap_q[idx_q];
          idx_d   = sel_i;
          // Stop right away if the new position is a leaf.
          if (sel_lc_w < count_ext) state_d = S_DOWN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      resp_q     <= '0;
      push_ack_q <= 1'b0;
      pop_ack_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      resp_q     <= resp_d;
      push_ack_q <= push_ack_d;
      pop_ack_q  <= pop_ack_d;
      err_q      <= err_d;
    end
  end

  // Heap storage carries no reset; its contents are qualified by count.
  always_ff @(posedge clk) begin
    if (we_a) heap_q[wa_idx] <= wa_data;
    if (we_b) heap_q[wb_idx] <= wb_data;
  end

endmodule

// File: tb/tb_heap_ctrl.sv
module tb_heap_ctrl;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              push_valid, pop_valid;
  logic [DATA_W-1:0] push_data;
  logic              ready, push_ack, pop_ack, full, empty, err;
  logic [DATA_W-1:0] resp_data;
  logic [$clog2(DEPTH):0] count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  heap_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .push_valid(push_valid),
    .pop_valid (pop_valid),
    .push_data (push_data),
    .ready     (ready),
    .push_ack  (push_ack),
    .pop_ack   (pop_ack),
    .resp_data (resp_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          p;
    bit          o;
    logic [31:0] d;
    bit          pa;
    bit          oa;
    bit          er;
    logic [31:0] resp;
    int          cnt;
    int          busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(bit p, bit o, logic [31:0] d, bit pa, bit oa, bit er,
                     logic [31:0] resp, int cnt, int busy);
    vec_t v;
    v.p = p; v.o = o; v.d = d; v.pa = pa; v.oa = oa; v.er = er;
    v.resp = resp; v.cnt = cnt; v.busy = busy;
    vq.push_back(v);
  endtask

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic check_le(string nm, int act, int lim);
    total_cnt++;
    if (act <= lim) pass_cnt++;
    else $display("FAIL %s: got %0d expected at most %0d", nm, act, lim);
  endtask

  task automatic wait_ready(string nm);
    int n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check({nm, " ready timeout"}, 64'(ready), 64'd1);
  endtask

  task automatic do_op(string nm, vec_t v);
    int busy;
    wait_ready(nm);
    @(negedge clk);
    push_valid = v.p; pop_valid = v.o; push_data = v.d;
    @(posedge clk); #1;
    check({nm, " push_ack"}, 64'(push_ack), 64'(v.pa));
    check({nm, " pop_ack"},  64'(pop_ack),  64'(v.oa));
    check({nm, " err"},      64'(err),      64'(v.er));
    check({nm, " resp"},     64'(resp_data), 64'(v.resp));
    check({nm, " count"},    64'(count),    64'(v.cnt));
    check({nm, " full"},     64'(full),     64'(v.cnt == DEPTH));
    check({nm, " empty"},    64'(empty),    64'(v.cnt == 0));
    @(negedge clk);
    push_valid = 1'b0; pop_valid = 1'b0;
    busy = ready ? 0 : 1;
    while (!ready && busy <= v.busy + 4) begin
      @(posedge clk); #1;
      if (!ready) busy++;
    end
    check_le({nm, " busy"}, busy, v.busy);
    @(posedge clk); #1;
    check({nm, " pulses clear"}, {61'd0, push_ack, pop_ack, err}, 64'd0);
  endtask

  task automatic op(string nm, bit p, bit o, logic [31:0] d, bit pa, bit oa,
                    bit er, logic [31:0] resp, int cnt, int busy);
    vec_t v;
    v.p = p; v.o = o; v.d = d; v.pa = pa; v.oa = oa; v.er = er;
    v.resp = resp; v.cnt = cnt; v.busy = busy;
    do_op(nm, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic ordering: push 5,3,8,1 then pop -> 1,3,5,8
    add(1, 0, 5, 1, 0, 0, 0, 1, 0);
    add(1, 0, 3, 1, 0, 0, 0, 2, 4);
    add(1, 0, 8, 1, 0, 0, 0, 3, 4);
    add(1, 0, 1, 1, 0, 0, 0, 4, 4);
    add(0, 1, 0, 0, 1, 0, 1, 3, 4);
    add(0, 1, 0, 0, 1, 0, 3, 2, 4);
    add(0, 1, 0, 0, 1, 0, 5, 1, 4);
    add(0, 1, 0, 0, 1, 0, 8, 0, 4);
    // Pop while empty: err only, resp unchanged
    add(0, 1, 0, 0, 0, 1, 8, 0, 0);
    // Duplicates: ties never cost more than one compare cycle
    add(1, 0, 6, 1, 0, 0, 8, 1, 0);
    add(1, 0, 6, 1, 0, 0, 8, 2, 1);
    add(1, 0, 6, 1, 0, 0, 8, 3, 1);
    add(0, 1, 0, 0, 1, 0, 6, 2, 1);
    add(0, 1, 0, 0, 1, 0, 6, 1, 0);
    add(0, 1, 0, 0, 1, 0, 6, 0, 0);
    // Fill with descending keys, overflow, then drain in order
    for (int k = 16; k >= 1; k--) add(1, 0, 32'(k), 1, 0, 0, 6, 17 - k, 4);
    add(1, 0, 0, 0, 0, 1, 6, 16, 0);
    for (int k = 1; k <= 16; k++) add(0, 1, 0, 0, 1, 0, 32'(k), 16 - k, 4);

    rst = 1'b1; push_valid = 1'b0; pop_valid = 1'b0; push_data = '0;
    repeat (3) @(negedge clk);
    check("reset count", 64'(count), 64'd0);
    check("reset ready", 64'(ready), 64'd1);
    check("reset resp",  64'(resp_data), 64'd0);
    check("reset pulses", {61'd0, push_ack, pop_ack, err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset empty", 64'(empty), 64'd1);
    check("post-reset full",  64'(full),  64'd0);

    foreach (vq[i]) do_op($sformatf("row%0d", i), vq[i]);

    // Simultaneous pop and push with heap {2,7}
    op("pp push2", 1, 0, 2, 1, 0, 0, 16, 1, 0);
    op("pp push7", 1, 0, 7, 1, 0, 0, 16, 2, 1);
    wait_ready("pp both");
    @(negedge clk);
    push_valid = 1'b1; pop_valid = 1'b1; push_data = 4;
    @(posedge clk); #1;
    check("pp pop_ack",  64'(pop_ack),  64'd1);
    check("pp push_ack", 64'(push_ack), 64'd0);
    check("pp resp",     64'(resp_data), 64'd2);
    check("pp count",    64'(count),    64'd1);
    check("pp ready",    64'(ready),    64'd1);
    @(negedge clk);
    pop_valid = 1'b0;
    @(posedge clk); #1;
    check("pp held push_ack", 64'(push_ack), 64'd1);
    check("pp held count",    64'(count),    64'd2);
    @(negedge clk);
    push_valid = 1'b0;
    op("pp pop4", 0, 1, 0, 0, 1, 0, 4, 1, 4);
    op("pp pop7", 0, 1, 0, 0, 1, 0, 7, 0, 4);

    // Requests arriving while sifting are ignored
    op("ig push1", 1, 0, 1, 1, 0, 0, 7, 1, 0);
    op("ig push5", 1, 0, 5, 1, 0, 0, 7, 2, 1);
    op("ig push6", 1, 0, 6, 1, 0, 0, 7, 3, 1);
    @(negedge clk);
    pop_valid = 1'b1;
    @(posedge clk); #1;
    check("ig pop_ack", 64'(pop_ack), 64'd1);
    check("ig resp",    64'(resp_data), 64'd1);
    check("ig busy",    64'(ready), 64'd0);
    @(negedge clk);
    pop_valid = 1'b0; push_valid = 1'b1; push_data = 0;
    @(posedge clk); #1;
    check("ig push_ack", 64'(push_ack), 64'd0);
    check("ig count",    64'(count),    64'd2);
    check("ig ready",    64'(ready),    64'd1);
    @(negedge clk);
    push_valid = 1'b0;

    // Reset during SIFT_DOWN: heap {5,6} + push 2 -> {2,6,5}, pop -> sift
    op("rs push2", 1, 0, 2, 1, 0, 0, 1, 3, 4);
    @(negedge clk);
    pop_valid = 1'b1;
    @(posedge clk); #1;
    check("rs pop_ack", 64'(pop_ack), 64'd1);
    check("rs resp",    64'(resp_data), 64'd2);
    check("rs sifting", 64'(ready), 64'd0);
    pop_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rs count", 64'(count), 64'd0);
    check("rs ready", 64'(ready), 64'd1);
    check("rs empty", 64'(empty), 64'd1);
    check("rs resp0", 64'(resp_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    op("rs push9", 1, 0, 9, 1, 0, 0, 0, 1, 0);
    op("rs pop9",  0, 1, 0, 0, 1, 0, 9, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
